// File: rtl/sub_reload_timer.sv
// Reloadable countdown timer with a programmable reload register.
// Supports single-shot and auto-reload (periodic) operation with a one-cycle expire pulse.
module sub_reload_timer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned RELOAD_DEFAULT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  localparam logic [WIDTH-1:0] RELOAD_RST = WIDTH'(RELOAD_DEFAULT);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] reload_reg;
  logic             per_latch;
  logic             zero_pend;

  assign cfg_rdata = reload_reg;

  // A start with a zero reload never goes busy; zero_pend produces its pulse one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_reg <= RELOAD_RST;
      count      <= '0;
      busy       <= 1'b0;
      expire     <= 1'b0;
      per_latch  <= 1'b0;
      zero_pend  <= 1'b0;
    end else begin
      if (cfg_we) begin
        reload_reg <= cfg_wdata;
      end
      expire    <= 1'b0;
      zero_pend <= 1'b0;
      if (stop) begin
        busy  <= 1'b0;
        count <= '0;
      end else if (start) begin
        per_latch <= periodic;
        if (reload_reg == '0) begin
          busy      <= 1'b0;
          count     <= '0;
          zero_pend <= 1'b1;
        end else begin
          busy  <= 1'b1;
          count <= reload_reg;
        end
      end else if (zero_pend) begin
        expire <= 1'b1;
      end else if (busy) begin
        if (count == ONE) begin
          expire <= 1'b1;
          // An auto-reload from a zero reload value would wrap, so it ends the run instead.
          if (per_latch && (reload_reg != '0)) begin
            count <= reload_reg;
          end else begin
            busy  <= 1'b0;
            count <= '0;
          end
        end else begin
          count <= count - ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_reload_timer.sv
// Self-checking bench for sub_reload_timer: vector table, directed corner sequences,
// and random stimulus against a deadline-based reference model.
module tb_sub_reload_timer;
  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [W-1:0]  cfg_wdata;
  logic [W-1:0]  cfg_rdata;
  logic          start, stop, periodic;
  logic [W-1:0]  count;
  logic          busy, expire;

  logic [W-1:0]  rdata_b, count_b;
  logic          busy_b, expire_b;

  always #5 clk = ~clk;

  sub_reload_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .start(start), .stop(stop), .periodic(periodic), .count(count), .busy(busy), .expire(expire)
  );

  sub_reload_timer #(.WIDTH(W), .RELOAD_DEFAULT(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_wdata('0), .cfg_rdata(rdata_b),
    .start(1'b0), .stop(1'b0), .periodic(1'b0), .count(count_b), .busy(busy_b), .expire(expire_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the absolute edge at which the next expiry is due.
  longint m_now, m_deadline, m_zero_at;
  longint m_reload;
  bit     m_busy, m_per, m_exp;

  task automatic model_reset();
    m_reload  = 10;
    m_busy    = 0;
    m_per     = 0;
    m_exp     = 0;
    m_zero_at = -1;
    m_deadline = 0;
  endtask

  task automatic model_edge();
    longint next_reload;
    m_now++;
    next_reload = cfg_we ? longint'(cfg_wdata) : m_reload;
    m_exp = 0;
    if (stop) begin
      m_busy = 0;
      m_zero_at = -1;
    end else if (start) begin
      m_per = periodic;
      m_zero_at = -1;
      if (m_reload == 0) begin
        m_busy = 0;
        m_zero_at = m_now + 1;
      end else begin
        m_busy = 1;
        m_deadline = m_now + m_reload;
      end
    end else if (m_zero_at == m_now) begin
      m_exp = 1;
      m_zero_at = -1;
    end else if (m_busy && m_now == m_deadline) begin
      m_exp = 1;
      if (m_per && m_reload != 0) m_deadline = m_now + m_reload;
      else m_busy = 0;
    end
    m_reload = next_reload;
  endtask

  function automatic longint m_count();
    return m_busy ? (m_deadline - m_now) : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_count", longint'(count), m_count());
    chk("model_busy", longint'(busy), longint'(m_busy));
    chk("model_expire", longint'(expire), longint'(m_exp));
    chk("model_rdata", longint'(cfg_rdata), m_reload);
  endtask

  task automatic cyc(input logic we, input logic [W-1:0] wd, input logic st, input logic sp,
                     input logic per);
    cfg_we = we; cfg_wdata = wd; start = st; stop = sp; periodic = per;
    step();
    cfg_we = 1'b0; cfg_wdata = '0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [W-1:0]  wd;
    logic          st, sp, per;
    logic [W-1:0]  e_cnt;
    logic          e_busy, e_exp;
    logic [W-1:0]  e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input int wd, input logic st, input logic sp,
                              input logic per, input int ec, input logic eb, input logic ee,
                              input int er);
    vec_t v;
    v.we = we; v.wd = W'(wd); v.st = st; v.sp = sp; v.per = per;
    v.e_cnt = W'(ec); v.e_busy = eb; v.e_exp = ee; v.e_rd = W'(er);
    return v;
  endfunction

  initial begin
    int first_exp;
    bit exp_p;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_wdata = '0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    m_now = 0;
    model_reset();
    #12;
    chk("rst_count", longint'(count), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_rdata", longint'(cfg_rdata), 10);
    chk("rst_rdata_override", longint'(rdata_b), 100);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Single shot with the default reload of 10.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("ss_count_first", longint'(count), 10);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("ss_expire", longint'(expire), (k == 10) ? 1 : 0);
      chk("ss_count", longint'(count), 10 - k);
    end
    chk("ss_busy_end", longint'(busy), 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ss_expire_single", longint'(expire), 0);

    // Vector table.
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 7, 1, 0, 0, 3, 1, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 7));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    foreach (tbl[i]) begin
      cyc(tbl[i].we, tbl[i].wd, tbl[i].st, tbl[i].sp, tbl[i].per);
      chk($sformatf("vec%0d_count", i), longint'(count), longint'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), longint'(busy), longint'(tbl[i].e_busy));
      chk($sformatf("vec%0d_expire", i), longint'(expire), longint'(tbl[i].e_exp));
      chk($sformatf("vec%0d_rdata", i), longint'(cfg_rdata), longint'(tbl[i].e_rd));
    end

    // Periodic 3, rewrite to 5 mid-run, then stop.
    cyc(1'b1, W'(3), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 28; k++) begin
      if (k == 10) cyc(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
      else if (k == 18) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      else cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      exp_p = (k == 3 || k == 6 || k == 9 || k == 12 || k == 17);
      chk($sformatf("per_expire_k%0d", k), longint'(expire), longint'(exp_p));
    end
    chk("per_busy_after_stop", longint'(busy), 0);

    // Stop on the expiry edge suppresses the pulse.
    cyc(1'b1, W'(2), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stopexp_count1", longint'(count), 1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("stopexp_expire", longint'(expire), 0);
    chk("stopexp_busy", longint'(busy), 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stopexp_expire_late", longint'(expire), 0);

    // Restart while busy at count 4.
    cyc(1'b1, W'(6), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("restart_pre_count", longint'(count), 4);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("restart_count", longint'(count), 6);
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("restart_expire_k%0d", k), longint'(expire), (k == 6) ? 1 : 0);
    end

    // Async reset mid-count, no clock edge needed.
    cyc(1'b1, W'(8), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_count", longint'(count), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", longint'(count), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_rdata", longint'(cfg_rdata), 10);
    chk("arst_rdata_override", longint'(rdata_b), 100);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("arst_no_expire", longint'(expire), 0);
    end

    // Maximum reload: expiry exactly 65535 edges after start.
    cyc(1'b1, W'(16'hFFFF), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("max_count_first", longint'(count), 65535);
    first_exp = -1;
    for (int k = 1; k <= 65540 && first_exp < 0; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (expire) first_exp = k;
    end
    chk("max_expire_edge", longint'(first_exp), 65535);
    chk("max_count_end", longint'(count), 0);
    chk("max_busy_end", longint'(busy), 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(7) == 0), W'($urandom_range(12)), ($urandom_range(9) == 0),
          ($urandom_range(19) == 0), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
